fir_seq: RTL

Tap sequencer that sits directly upstream of fir_alu. It accepts Q1.15 input samples over a valid/ready handshake and stores them in a circular delay line. It holds a programmable Q1.15 coefficient bank, steps fir_alu through one clear cycle and NTAPS MAC cycles per sample, and captures fir_alu's Q7.9 result into a valid/ready output register.

---
 rtl/fir_seq.sv | 134 +++++++++++++
 1 files changed

// File: rtl/fir_seq.sv
// rtl/fir_seq.sv - FIR tap sequencer: sample delay line, coefficient bank, fir_alu stepping, result register
module fir_seq #(
  parameter int NTAPS = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [15:0]   s_data,
  input  logic          coef_we,
  input  logic [AW-1:0] coef_addr,
  input  logic [15:0]   coef_wdata,
  output logic          en_mac,
  output logic          clr_acc,
  output logic [15:0]   a_q15,
  output logic [15:0]   b_q15,
  input  logic [15:0]   y_in,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [15:0]   m_data,
  output logic          busy
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_MAC,
    ST_CAP,
    ST_OUT
  } state_t;

  state_t        r_state;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_cur_ptr;
  logic [AW-1:0] r_k;
  logic          r_started;
  logic          r_m_valid;
  logic [15:0]   r_m_data;
  logic [15:0]   r_line [NTAPS];
  logic [15:0]   r_coef [NTAPS];

  logic          w_idle;
  logic          w_accept;
  logic          w_coef_wr;
  logic [AW-1:0] w_tap_idx;

  // r_started keeps s_ready low while reset is held and for the release cycle
  assign w_idle    = (r_state == ST_IDLE) && r_started;
  assign w_accept  = w_idle && s_valid;
  assign w_coef_wr = w_idle && coef_we;
  // newest sample (cur_ptr) pairs with coef[0]; older samples walk backwards
  assign w_tap_idx = r_cur_ptr - r_k;

  // fir_alu controls decoded purely from registered state, counter and storage
  always_comb begin
    s_ready = w_idle;
    busy    = (r_state != ST_IDLE);
    clr_acc = (r_state == ST_CLR);
    en_mac  = (r_state == ST_MAC);
    a_q15   = 16'd0;
    b_q15   = 16'd0;
    if (r_state == ST_MAC) begin
      a_q15 = r_line[w_tap_idx];
      b_q15 = r_coef[r_k];
    end
    m_valid = r_m_valid;
    m_data  = r_m_data;
  end

  // sequencing FSM: pointers, tap counter and the output result register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= ST_IDLE;
      r_wr_ptr  <= '0;
      r_cur_ptr <= '0;
      r_k       <= '0;
      r_started <= 1'b0;
      r_m_valid <= 1'b0;
      r_m_data  <= 16'd0;
    end else begin
      r_started <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_cur_ptr <= r_wr_ptr;
            r_wr_ptr  <= r_wr_ptr + 1'b1;
            r_state   <= ST_CLR;
          end
        end
        ST_CLR: begin
          r_k     <= '0;
          r_state <= ST_MAC;
        end
        ST_MAC: begin
          r_k <= r_k + 1'b1;
          if (r_k == {AW{1'b1}}) begin
            r_state <= ST_CAP;
          end
        end
        ST_CAP: begin
          r_m_data  <= y_in;
          r_m_valid <= 1'b1;
          r_state   <= ST_OUT;
        end
        ST_OUT: begin
          if (m_ready) begin
            r_m_valid <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // delay line and coefficient bank; both only change while idle
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NTAPS; i++) begin
        r_line[i] <= 16'd0;
        r_coef[i] <= 16'd0;
      end
    end else begin
      if (w_accept) begin
        r_line[r_wr_ptr] <= s_data;
      end
      if (w_coef_wr) begin
        r_coef[coef_addr] <= coef_wdata;
      end
    end
  end

endmodule
